time_set_ctrl: RTL and testbench

//   Time-of-day controller for the 24 h digital clock display.
//   - Divides clk1 down to a 1 s tick.
//   - Sequences BCD seconds, minutes and hours counters with carries.
//   - Runs a set-mode FSM so the user can adjust hours and minutes with two buttons.
//   - Outputs feed the 7-segment scan/decoder block directly.

---
 rtl/time_set_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-of-day controller: 1 s prescaler, BCD hh:mm:ss counters with carries,
// and a three-state set-mode FSM driven by the mode/increment buttons.
module time_set_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int BLINK_DIV = 500
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] hr_tens,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          btn_mode_q_r, btn_inc_q_r;
  logic [PW-1:0] presc_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r, sec_tick_r;
  logic [3:0]    sec_ones_r, min_ones_r, hr_ones_r;
  logic [2:0]    sec_tens_r, min_tens_r, hr_tens_r;

  logic mode_press_s, inc_press_s, tick_s;
  logic sec_step_s, min_step_s, hr_step_s, sec_clear_s, enter_set_s;

  // A mode press always wins over a simultaneous increment press.
  assign mode_press_s = btn_mode & ~btn_mode_q_r;
  assign inc_press_s  = btn_inc & ~btn_inc_q_r & ~mode_press_s;
  assign tick_s       = (state_r == ST_RUN) && (presc_r == PRESC_MAX);

  assign sec_ones = sec_ones_r;
  assign sec_tens = sec_tens_r;
  assign min_ones = min_ones_r;
  assign min_tens = min_tens_r;
  assign hr_ones  = hr_ones_r;
  assign hr_tens  = hr_tens_r;
  assign mode     = state_r;
  assign blink    = blink_r;
  assign sec_tick = sec_tick_r;

  // Next-state decode and per-field step/clear events for this edge.
  always_comb begin
    state_nxt_s = state_r;
    sec_step_s  = 1'b0;
    min_step_s  = 1'b0;
    hr_step_s   = 1'b0;
    sec_clear_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        sec_step_s = tick_s;
        min_step_s = tick_s && (sec_tens_r == 3'd5) && (sec_ones_r == 4'd9);
        hr_step_s  = min_step_s && (min_tens_r == 3'd5) && (min_ones_r == 4'd9);
        if (mode_press_s) state_nxt_s = ST_SET_HR;
        else              state_nxt_s = ST_RUN;
      end
      ST_SET_HR: begin
        hr_step_s = inc_press_s;
        if (mode_press_s) state_nxt_s = ST_SET_MIN;
        else              state_nxt_s = ST_SET_HR;
      end
      ST_SET_MIN: begin
        min_step_s = inc_press_s;
        if (mode_press_s) begin
          state_nxt_s = ST_RUN;
          sec_clear_s = 1'b1;
        end else begin
          state_nxt_s = ST_SET_MIN;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
    enter_set_s = (state_nxt_s != state_r) &&
                  ((state_nxt_s == ST_SET_HR) || (state_nxt_s == ST_SET_MIN));
  end

  // FSM state register.
  always_ff @(posedge clk1) begin
    if (!rst) state_r <= ST_RUN;
    else      state_r <= state_nxt_s;
  end

  // Button history for rising-edge detection.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      btn_mode_q_r <= 1'b0;
      btn_inc_q_r  <= 1'b0;
    end else begin
      btn_mode_q_r <= btn_mode;
      btn_inc_q_r  <= btn_inc;
    end
  end

  // Prescaler runs only in RUN; restarts on wrap and when leaving RUN.
  always_ff @(posedge clk1) begin
    if (!rst)                                               presc_r <= '0;
    else if ((state_r == ST_RUN) && !tick_s && !mode_press_s) presc_r <= presc_r + PW'(1);
    else                                                    presc_r <= '0;
  end

  // Registered copy of the internal second tick.
  always_ff @(posedge clk1) begin
    if (!rst) sec_tick_r <= 1'b0;
    else      sec_tick_r <= tick_s;
  end

  // Seconds counter 00..59, cleared when leaving SET_MIN.
  always_ff @(posedge clk1) begin
    if (!rst || sec_clear_s) begin
      sec_ones_r <= 4'd0;
      sec_tens_r <= 3'd0;
    end else if (sec_step_s) begin
      if (sec_ones_r == 4'd9) begin
        sec_ones_r <= 4'd0;
        sec_tens_r <= (sec_tens_r == 3'd5) ? 3'd0 : sec_tens_r + 3'd1;
      end else begin
        sec_ones_r <= sec_ones_r + 4'd1;
      end
    end
  end

  // Minutes counter 00..59.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      min_ones_r <= 4'd0;
      min_tens_r <= 3'd0;
    end else if (min_step_s) begin
      if (min_ones_r == 4'd9) begin
        min_ones_r <= 4'd0;
        min_tens_r <= (min_tens_r == 3'd5) ? 3'd0 : min_tens_r + 3'd1;
      end else begin
        min_ones_r <= min_ones_r + 4'd1;
      end
    end
  end

  // Hours counter 00..23; 23 wraps straight to 00.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      hr_ones_r <= 4'd0;
      hr_tens_r <= 3'd0;
    end else if (hr_step_s) begin
      if ((hr_tens_r == 3'd2) && (hr_ones_r == 4'd3)) begin
        hr_ones_r <= 4'd0;
        hr_tens_r <= 3'd0;
      end else if (hr_ones_r == 4'd9) begin
        hr_ones_r <= 4'd0;
        hr_tens_r <= hr_tens_r + 3'd1;
      end else begin
        hr_ones_r <= hr_ones_r + 4'd1;
      end
    end
  end

  // Blink strobe: restarts low on entry to a set mode, toggles every BLINK_DIV cycles.
  always_ff @(posedge clk1) begin
    if (!rst || enter_set_s ||
        ((state_r != ST_SET_HR) && (state_r != ST_SET_MIN))) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_MAX) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with TICK_DIV=4, BLINK_DIV=2.
module tb_time_set_ctrl;

  logic       clk1 = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens, hr_tens;
  logic [1:0] mode;
  logic       blink, sec_tick;

  int checks = 0;
  int errors = 0;
  int bad_hr = 0;
  int tick_cnt = 0;
  int tick_before;

  time_set_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk1(clk1), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
    .mode(mode), .blink(blink), .sec_tick(sec_tick)
  );

  // 10 time-unit clock.
  always #5 clk1 = ~clk1;

  // Hour-field legality and sec_tick pulse counting, sampled on the falling edge.
  always @(negedge clk1) begin
    if ((hr_tens > 3'd2) || (hr_ones > 4'd9) || ((hr_tens == 3'd2) && (hr_ones > 4'd3)))
      bad_hr++;
    if (sec_tick === 1'b1) tick_cnt++;
  end

  function automatic logic [31:0] hours();
    return 32'(hr_tens) * 32'd10 + 32'(hr_ones);
  endfunction
  function automatic logic [31:0] minutes();
    return 32'(min_tens) * 32'd10 + 32'(min_ones);
  endfunction
  function automatic logic [31:0] seconds();
    return 32'(sec_tens) * 32'd10 + 32'(sec_ones);
  endfunction
  function automatic logic [31:0] hms();
    return hours() * 32'd10000 + minutes() * 32'd100 + seconds();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    step(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    step(1);
    btn_inc = 1'b0;
    step(1);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_hms", hms(), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_tick", 32'(sec_tick), 32'd0);

    // 1: release reset, ticks after edges 4, 8, 12
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check("t1_tick", 32'(sec_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("t1_sec", seconds(), 32'd3);

    // 2: preload 23:59 via set mode, then ticks to 23:59:58
    press_mode();
    check("t2_mode_hr", 32'(mode), 32'd1);
    repeat (23) press_inc();
    check("t2_hr23", hours(), 32'd23);
    press_mode();
    check("t2_mode_min", 32'(mode), 32'd2);
    repeat (59) press_inc();
    check("t2_min59", minutes(), 32'd59);
    check("t2_sec_frozen", seconds(), 32'd3);
    press_mode();
    check("t2_mode_run", 32'(mode), 32'd0);
    check("t2_sec_clr", seconds(), 32'd0);
    step(231);
    check("t2_235958", hms(), 32'd235958);
    step(4);
    check("t2_235959", hms(), 32'd235959);
    step(4);
    check("t2_wrap", hms(), 32'd0);

    // 3: 25 hour increments from 00 in SET_HR
    press_mode();
    check("t3_mode", 32'(mode), 32'd1);
    tick_before = tick_cnt;
    for (int k = 1; k <= 25; k++) begin
      press_inc();
      check("t3_hr", hours(), 32'(k % 24));
    end
    check("t3_min", minutes(), 32'd0);
    check("t3_sec", seconds(), 32'd0);
    check("t3_noticks", 32'(tick_cnt), 32'(tick_before));

    // 4: minute wrap without carry, then exit to RUN and tick timing
    press_mode();
    check("t4_mode", 32'(mode), 32'd2);
    repeat (59) press_inc();
    check("t4_min59", minutes(), 32'd59);
    press_inc();
    check("t4_min00", minutes(), 32'd0);
    check("t4_hr", hours(), 32'd1);
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    check("t4_run", 32'(mode), 32'd0);
    check("t4_sec", seconds(), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("t4_tick", 32'(sec_tick), (i == 4) ? 32'd1 : 32'd0);
      check("t4_secv", seconds(), (i == 4) ? 32'd1 : 32'd0);
    end

    // 5: simultaneous presses, then held inc
    press_mode();
    check("t5_mode_hr", 32'(mode), 32'd1);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step(1);
    check("t5_mode_min", 32'(mode), 32'd2);
    check("t5_hr", hours(), 32'd1);
    check("t5_min", minutes(), 32'd0);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(1);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(1);
    check("t5_hold_min", minutes(), 32'd1);
    check("t5_hold_hr", hours(), 32'd1);

    // 6: blink in SET_MIN, then reset mid-blink
    press_mode();
    check("t6_run", 32'(mode), 32'd0);
    check("t6_sec_clr", seconds(), 32'd0);
    press_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    check("t6_mode", 32'(mode), 32'd2);
    check("t6_blink0", 32'(blink), 32'd0);
    step(1);
    check("t6_blink1", 32'(blink), 32'd0);
    step(1);
    check("t6_blink2", 32'(blink), 32'd1);
    rst = 1'b0;
    step(1);
    check("t6_hms", hms(), 32'd0);
    check("t6_mode_rst", 32'(mode), 32'd0);
    check("t6_blink_rst", 32'(blink), 32'd0);
    check("t6_tick_rst", 32'(sec_tick), 32'd0);
    rst = 1'b1;
    step(1);

    check("hr_legal", 32'(bad_hr), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
